// File: rtl/fb_pkg.sv
// Shared constants for the framebuffer arbiter: default bus widths, the slot
// frame layout and the framebuffer RAM read latency.
package fb_pkg;

    localparam int AW        = 17;
    localparam int DW        = 12;
    localparam int SLOTS     = 4;
    localparam int SLOT_W    = $clog2(SLOTS);
    localparam int RD_LAT    = 1;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_SCAN = slot_t'(0);

endpackage

// File: rtl/fb_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant to the first requester found after
// the most recently granted index; the pointer only moves when a grant is issued.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_q, last_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt    = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                last_d   = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Reset to the highest index so writer 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: slot 0 of every 4-cycle frame serves VGA
// scanout reads, all other (and unused scan) slots serve round-robin writers.
module fb_arbiter #(
    parameter int AW   = fb_pkg::AW,
    parameter int DW   = fb_pkg::DW,
    parameter int N_WR = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_tick,
    input  logic               scan_req,
    input  logic [AW-1:0]      scan_addr,
    output logic [DW-1:0]      scan_data,
    output logic               scan_valid,
    input  logic [N_WR-1:0]    wr_req,
    input  logic [N_WR*AW-1:0] wr_addr,
    input  logic [N_WR*DW-1:0] wr_data,
    output logic [N_WR-1:0]    wr_gnt,
    output logic [AW-1:0]      ram_addr,
    output logic               ram_we,
    output logic [DW-1:0]      ram_wdata,
    input  logic [DW-1:0]      ram_rdata
);

    import fb_pkg::*;

    slot_t          slot_q, slot_d;
    logic [AW-1:0]  ram_addr_q, ram_addr_d;
    logic [DW-1:0]  ram_wdata_q, ram_wdata_d;
    logic           ram_we_q, ram_we_d;
    logic [DW-1:0]  scan_data_q, scan_data_d;
    logic           scan_valid_q, scan_valid_d;
    logic [RD_LAT:0] rd_v_q, rd_v_d;

    logic           scan_take;
    logic           wr_en;
    logic [N_WR-1:0] gnt_w;
    logic [AW-1:0]  wa [N_WR];
    logic [DW-1:0]  wd [N_WR];
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_data;

    assign scan_take = (slot_q == SLOT_SCAN) && scan_req;
    assign wr_en     = !rst && !scan_take;

    rr_arbiter #(.N(N_WR)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .en  (wr_en),
        .gnt (gnt_w)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_WR; gi++) begin : g_unpack
            assign wa[gi] = wr_addr[gi*AW +: AW];
            assign wd[gi] = wr_data[gi*DW +: DW];
        end
    endgenerate

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_WR; i++) begin
            if (gnt_w[i]) begin
                sel_addr = sel_addr | wa[i];
                sel_data = sel_data | wd[i];
            end
        end
    end

    always_comb begin
        slot_d      = (slot_q == slot_t'(SLOTS - 1)) ? '0 : slot_q + slot_t'(1);
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        if (scan_take) begin
            ram_addr_d = scan_addr;
        end else if (|gnt_w) begin
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_data;
            ram_we_d    = 1'b1;
        end
        // Valid travels alongside the RAM access; the tail captures ram_rdata.
        rd_v_d       = {rd_v_q[RD_LAT-1:0], scan_take};
        scan_valid_d = rd_v_q[RD_LAT];
        scan_data_d  = rd_v_q[RD_LAT] ? ram_rdata : scan_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
            rd_v_q       <= '0;
        end else begin
            slot_q       <= slot_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            scan_data_q  <= scan_data_d;
            scan_valid_q <= scan_valid_d;
            rd_v_q       <= rd_v_d;
        end
    end

    assign pix_tick   = !rst && (slot_q == SLOT_SCAN);
    assign wr_gnt     = gnt_w;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer access arbiter between VGA scanout and the game-logic writers (tank/bullet renderers). Divides the 100 MHz `clk` into a repeating 4-cycle slot frame: slot 0 belongs to scanout, which reads one pixel per frame (25 MHz pixel rate); remaining slots, and any unused slot 0, go to writers under round-robin arbitration. Sits between the framebuffer BRAM and `vga_out`, and emits the pixel tick that `vga_out` uses as its pixel enable.

## Interface
- `AW`, 17, framebuffer address width (320x240 = 76800 words)
- `DW`, 12, pixel width (4:4:4 RGB, matches `pix_r/g/b`)
- `N_WR`, 2, number of writer ports (2..4)
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous, active-high reset
- `pix_tick`  out  1  high while slot counter == 0; scanout pixel enable
- `scan_req`  in  1  scanout wants a read this frame; sampled only in slot 0
- `scan_addr`  in  AW  read address, sampled with `scan_req`
- `scan_data`  out  DW  read pixel
- `scan_valid`  out  1  one-cycle strobe, `scan_data` valid
- `wr_req`  in  N_WR  per-writer request; held with addr/data until granted
- `wr_addr`  in  N_WR*AW  packed write addresses, writer i at [i*AW +: AW]
- `wr_data`  in  N_WR*DW  packed write data
- `wr_gnt`  out  N_WR  one-hot grant, combinational, same cycle as acceptance
- `ram_addr`  out  AW  registered RAM address
- `ram_we`  out  1  registered write enable
- `ram_wdata`  out  DW  registered write data
- `ram_rdata`  in  DW  RAM read data, 1-cycle latency after `ram_addr`

## Operation
- 2-bit slot counter, free-running 0,1,2,3,0,...; reset to 0.
- Slot 0 with `scan_req`=1: register `ram_addr`=`scan_addr`, `ram_we`=0; no grant issued.
- Slot 0 with `scan_req`=0, or slots 1-3: if any `wr_req` set, grant exactly one writer; register its addr/data onto `ram_*` with `ram_we`=1.
- No requester: `ram_we`=0, `ram_addr`/`ram_wdata` hold previous values.
- Round-robin: pointer `last` = most recently granted writer; grant lowest set index searching cyclically from `last`+1. Pointer updates only on grant. Reset value N_WR-1 (writer 0 first).
- Handshake: writer sees `wr_gnt[i]`=1 at rising edge, transaction complete; writer presents next word or drops `wr_req` next cycle. `wr_gnt` never high for a writer with `wr_req`=0.
- Read return: 3-stage valid pipeline (sample -> RAM addr -> RAM data -> `scan_data` register).
- No address range checking; addresses pass through unchanged.

## Timing
- Reset values: slot=0, `ram_addr`=0, `ram_we`=0, `ram_wdata`=0, `scan_data`=0, `scan_valid`=0, `wr_gnt`=0, `pix_tick`=0 (forced low while `rst`), pointer=N_WR-1, read pipeline cleared.
- First cycle after `rst` deasserts is slot 0, `pix_tick`=1.
- Write: grant in cycle t -> `ram_we`=1 with addr/data in cycle t+1.
- Read: sampled in slot-0 cycle t -> `scan_valid`=1 and `scan_data` in t+3, exactly one cycle; max one read per 4 cycles.
- `rst` mid-operation: pending reads dropped (no `scan_valid`), any in-flight `ram_we` cleared next cycle, slot restarts at 0.
- `scan_req` outside slot 0 ignored.
- Max write throughput: 3 per frame with scanout active, 4 with scanout idle.

## Structure
- Shared package `fb_pkg`: `AW`/`DW` defaults, `SLOT_SCAN`=0, `SLOTS`=4, `RD_LAT`=1.
- Sub-module `rr_arbiter` (N-way round-robin, inputs req/en, outputs one-hot gnt, internal pointer); everything else in `fb_arbiter`.

## Test plan
- Reset: `rst`=1 for 3 cycles with all requests high -> all outputs 0, no grants; first cycle after release `pix_tick`=1, then every 4th cycle.
- Scan only: `scan_req`=1 constant, `scan_addr`=0x00010, RAM model returns addr-based data -> `scan_valid` every 4 cycles, 3 cycles after each slot 0, `scan_data`=model(0x00010), `ram_we` always 0.
- Single write: writer 0 req in slot 1, addr 0x00123, data 0xF0A -> `wr_gnt`=01 that cycle; next cycle `ram_we`=1, `ram_addr`=0x00123, `ram_wdata`=0xF0A.
- Contention: both writers and `scan_req` constant high -> slots 1,2,3 grant 0,1,0; next frame grants 1,0,1; no grant in slot 0.
- Idle scan slot: `scan_req`=0, only writer 1 requesting from slot 0 -> `wr_gnt`=10 in slot 0; writes in 4 consecutive cycles.
- Reset mid-read: `scan_req` sampled in slot 0, `rst` pulsed the next cycle -> `scan_valid` never asserts for that read, `ram_we`=0, slot resumes at 0.
